exp_block_accumulator: RTL and testbench
========================================

// Module: exp_block_accumulator
// PURPOSE
//  Downstream consumer of the pipelined exp(x) Taylor evaluator. Sums a block of
//  Q7.25 exp results (e.g. a softmax denominator) and emits one sum per block with a
//  valid/ready handshake. Its o_ready drives the evaluator's i_ready, so a held
//  result stalls the evaluator pipeline.
// PARAMETERS
//  WIDTHIN    32  input sample width, unsigned Q7.25
//  ACCW       35  accumulator/sum width, unsigned Q10.25 (WIDTHIN+clog2(BLOCK_LEN))
//  BLOCK_LEN  8   samples per block, >=1
//  CNTW       4   count width, must hold BLOCK_LEN
// PORTS
//  clk      in   1        clock
//  reset    in   1        asynchronous, active-high
//  i_valid  in   1        sample valid (evaluator o_valid)
//  i_y      in   WIDTHIN  sample (evaluator o_y)
//  i_last   in   1        sample closes the block early (sampled with i_valid)
//  o_ready  out  1        can accept a sample this cycle (to evaluator i_ready)
//  o_valid  out  1        o_sum/o_count valid
//  i_ready  in   1        downstream accepts o_sum
//  o_sum    out  ACCW     block sum, Q10.25
//  o_count  out  CNTW     samples in this sum (1..BLOCK_LEN)
//  o_ovf    out  1        sum saturated (EXP_ACC_SAT_EN only)
// BEHAVIOUR
//  - Accept = i_valid & o_ready; output handoff = o_valid & i_ready.
//  - i_y zero-extended to ACCW; no fraction realignment (both Q.25).
//  - FSM ACCUM: o_ready=1, o_valid=0. On accept: acc+=i_y, cnt+=1. If cnt+1==BLOCK_LEN
//    or i_last: o_sum<=acc+i_y, o_count<=cnt+1, acc<=0, cnt<=0, go HOLD.
//  - FSM HOLD: o_valid=1; o_sum/o_count/o_ovf stable until handoff; o_ready=i_ready
//    (combinational). On handoff without accept -> ACCUM. On handoff with accept
//    (same cycle): sample starts next block (acc<=i_y, cnt<=1); if it also closes the
//    block (BLOCK_LEN==1 or i_last) load new o_sum/o_count and stay HOLD; else ACCUM.
//  - i_valid while o_ready=0: sample not consumed; source must hold it.
//  - Latency: sum valid the cycle after the block's final accept; throughput one
//    sample/cycle while i_ready stays high.
//  - Reset (any state, mid-block): state=ACCUM, acc=0, cnt=0, o_valid=0, o_sum=0,
//    o_count=0, o_ovf=0; partial block discarded. o_ready=1 after reset.
//  - i_last on a sample that already makes cnt==BLOCK_LEN: single close, count BLOCK_LEN.
//  - i_last ignored unless accepted.
// CONFIGURATION
//  EXP_ACC_SAT_EN defined: each add saturates at 2^ACCW-1; o_ovf set with the sum of
//    any block that saturated, cleared when a block's sum is loaded without saturation.
//  Not defined: adds wrap modulo 2^ACCW; o_ovf tied 0.
// TESTING
//  1 Reset, 8 accepts of 0x0200_0000 (1.0), i_ready=1 -> next cycle o_valid=1,
//    o_sum=0x0_1000_0000 (8.0), o_count=8; ACCUM after one cycle.
//  2 Back-to-back 16 samples of 0x0200_0000, i_ready=1 -> two sums of 8.0, o_ready
//    never low, no sample lost.
//  3 Block done, i_ready=0 for 5 cycles with i_valid=1 -> o_ready=0, o_sum stable;
//    raise i_ready -> handoff and first sample of next block accepted same cycle.
//  4 3 samples 0x0100_0000 (0.5), third with i_last -> o_sum=0x0_0300_0000, o_count=3.
//  5 Assert reset after 4 samples -> o_valid=0, o_sum=0; next 8 samples of 1.0 -> 8.0.
//  6 8 samples 0xFFFF_FFFF: no macro -> o_sum=0x7_FFFF_FFF8, o_ovf=0; with
//    EXP_ACC_SAT_EN and ACCW=32 -> o_sum=0xFFFF_FFFF, o_ovf=1.

Source files
------------

// File: rtl/exp_acc_if.sv
// exp_acc_if
//   Bundles the sample input stream (from the exp(x) evaluator) and the
//   block-sum output stream of exp_block_accumulator.
//   master : drives samples and downstream ready, observes sums (evaluator/sink side)
//   slave  : the accumulator itself
//   Signals: i_valid, i_y[WIDTHIN], i_last, o_ready  - sample handshake
//            o_valid, i_ready, o_sum[ACCW], o_count[CNTW], o_ovf - sum handshake
interface exp_acc_if #(
    parameter int WIDTHIN = 32,
    parameter int ACCW    = 35,
    parameter int CNTW    = 4
);
    logic               i_valid;
    logic [WIDTHIN-1:0] i_y;
    logic               i_last;
    logic               o_ready;
    logic               o_valid;
    logic               i_ready;
    logic [ACCW-1:0]    o_sum;
    logic [CNTW-1:0]    o_count;
    logic               o_ovf;

    modport master (
        output i_valid, i_y, i_last, i_ready,
        input  o_ready, o_valid, o_sum, o_count, o_ovf
    );

    modport slave (
        input  i_valid, i_y, i_last, i_ready,
        output o_ready, o_valid, o_sum, o_count, o_ovf
    );
endinterface

// File: rtl/exp_block_accumulator.sv
// exp_block_accumulator
//   Sums blocks of unsigned Q7.25 exp(x) samples into Q10.25 block sums (e.g. a
//   softmax denominator). One sum per block of BLOCK_LEN samples, or fewer when a
//   sample arrives with i_last. The sum is held with o_valid until downstream
//   takes it; while held, o_ready follows i_ready so the evaluator stalls.
//   Ports:
//     clk    - clock
//     reset  - asynchronous, active-high
//     bus    - exp_acc_if.slave (sample in: i_valid/i_y/i_last/o_ready,
//              sum out: o_valid/i_ready/o_sum/o_count/o_ovf)
//   Build option:
//     EXP_ACC_SAT_EN - adds saturate at 2^ACCW-1 and o_ovf flags saturated
//                      blocks; otherwise adds wrap and o_ovf is tied low.
module exp_block_accumulator #(
    parameter int WIDTHIN   = 32,
    parameter int ACCW      = 35,
    parameter int BLOCK_LEN = 8,
    parameter int CNTW      = 4
) (
    input  logic        clk,
    input  logic        reset,
    exp_acc_if.slave    bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    state_t          state, state_nx;
    logic            ready_c, valid_c;
    logic            accept, handoff, closes;
    logic [ACCW-1:0] y_ext, acc, add_sum, sum_q;
    logic [CNTW-1:0] cnt, cnt_inc, count_q;

`ifdef EXP_ACC_SAT_EN
    logic            add_ovf, blk_sat, ovf_q;

    // Returns {saturated, sum}; clamps to all-ones on carry out.
    function automatic logic [ACCW:0] add_acc(input logic [ACCW-1:0] a,
                                              input logic [ACCW-1:0] b);
        logic [ACCW:0] full;
        full = {1'b0, a} + {1'b0, b};
        if (full[ACCW])
            return {1'b1, {ACCW{1'b1}}};
        return full;
    endfunction

    assign {add_ovf, add_sum} = add_acc(acc, y_ext);
    assign bus.o_ovf          = ovf_q;
`else
    // Plain modulo-2^ACCW add.
    function automatic logic [ACCW-1:0] add_acc(input logic [ACCW-1:0] a,
                                                input logic [ACCW-1:0] b);
        return a + b;
    endfunction

    assign add_sum   = add_acc(acc, y_ext);
    assign bus.o_ovf = 1'b0;
`endif

    // Both formats carry 25 fraction bits, so only zero-extension is needed.
    assign y_ext   = ACCW'(bus.i_y);
    assign cnt_inc = cnt + CNTW'(1);
    assign closes  = (cnt_inc == CNTW'(BLOCK_LEN)) | bus.i_last;
    assign accept  = bus.i_valid & ready_c;
    assign handoff = valid_c & bus.i_ready;

    assign bus.o_ready = ready_c;
    assign bus.o_valid = valid_c;
    assign bus.o_sum   = sum_q;
    assign bus.o_count = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ACCUM;
        else
            state <= state_nx;
    end

    // In HOLD an accept is only possible together with a handoff, because
    // o_ready equals i_ready there.
    always_comb begin
        state_nx = state;
        case (state)
            ACCUM:   if (accept && closes) state_nx = HOLD;
            HOLD:    if (handoff) state_nx = (accept && closes) ? HOLD : ACCUM;
            default: state_nx = ACCUM;
        endcase
    end

    always_comb begin
        ready_c = 1'b1;
        valid_c = 1'b0;
        if (state == HOLD) begin
            valid_c = 1'b1;
            ready_c = bus.i_ready;
        end
    end

    // acc/cnt are cleared whenever a block closes, so during HOLD they are
    // already zero and a same-cycle accept naturally starts the next block
    // with acc=i_y, cnt=1 through the same adder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            cnt     <= '0;
            sum_q   <= '0;
            count_q <= '0;
`ifdef EXP_ACC_SAT_EN
            blk_sat <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else if (accept) begin
            if (closes) begin
                sum_q   <= add_sum;
                count_q <= cnt_inc;
                acc     <= '0;
                cnt     <= '0;
`ifdef EXP_ACC_SAT_EN
                ovf_q   <= blk_sat | add_ovf;
                blk_sat <= 1'b0;
`endif
            end else begin
                acc     <= add_sum;
                cnt     <= cnt_inc;
`ifdef EXP_ACC_SAT_EN
                blk_sat <= blk_sat | add_ovf;
`endif
            end
        end
    end
endmodule

// File: tb/tb_exp_block_accumulator.sv
// tb_exp_block_accumulator
//   Drives exp_block_accumulator through directed block scenarios and a long
//   randomized run, comparing against a block-level model (list of accepted
//   samples, summed arithmetically when the block closes).
module tb_exp_block_accumulator;
    localparam int WIDTHIN   = 32;
`ifdef EXP_ACC_SAT_EN
    localparam int ACCW      = 32;
`else
    localparam int ACCW      = 35;
`endif
    localparam int BLOCK_LEN = 8;
    localparam int CNTW      = 4;

    typedef struct {
        longint unsigned sum;
        int              cnt;
        bit              ovf;
    } res_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    exp_acc_if #(.WIDTHIN(WIDTHIN), .ACCW(ACCW), .CNTW(CNTW)) bus ();

    exp_block_accumulator #(
        .WIDTHIN(WIDTHIN), .ACCW(ACCW), .BLOCK_LEN(BLOCK_LEN), .CNTW(CNTW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    longint unsigned blk[$];
    res_t            expq[$];
    res_t            last_res;
    bit              last_stall;

    localparam longint unsigned MAXV = (64'd1 << ACCW) - 64'd1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic close_block();
        res_t            r;
        longint unsigned total = 0;
        foreach (blk[i]) total += blk[i];
`ifdef EXP_ACC_SAT_EN
        r.ovf = (total > MAXV);
        r.sum = r.ovf ? MAXV : total;
`else
        r.ovf = 1'b0;
        r.sum = total & MAXV;
`endif
        r.cnt = blk.size();
        expq.push_back(r);
        blk.delete();
    endtask

    // One clock cycle: drive at negedge, check and update the model 1ns later.
    task automatic step(input bit v, input logic [31:0] y, input bit last, input bit rdy);
        bit acc_now, hand;
        @(negedge clk);
        bus.i_valid = v;
        bus.i_y     = y;
        bus.i_last  = last;
        bus.i_ready = rdy;
        #1;
        chk("o_valid", bus.o_valid, expq.size() != 0);
        chk("o_ready", bus.o_ready, (expq.size() == 0) || rdy);
        if (expq.size() != 0) begin
            chk("o_sum", bus.o_sum, expq[0].sum);
            chk("o_count", bus.o_count, expq[0].cnt);
            chk("o_ovf", bus.o_ovf, expq[0].ovf);
        end
        acc_now = v && bus.o_ready;
        hand    = bus.o_valid && rdy;
        if (hand && expq.size() != 0) last_res = expq.pop_front();
        if (acc_now) begin
            blk.push_back(longint'(y));
            if (blk.size() == BLOCK_LEN || last) close_block();
        end
        last_stall = v && !bus.o_ready;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.i_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst o_valid", bus.o_valid, 1'b0);
        chk("rst o_ready", bus.o_ready, 1'b1);
        chk("rst o_sum", bus.o_sum, 0);
        chk("rst o_count", bus.o_count, 0);
        chk("rst o_ovf", bus.o_ovf, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        blk.delete();
        expq.delete();
        last_stall = 1'b0;
    endtask

    task automatic drain();
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [31:0] hy;
        bit          hv, hl;
        reset       = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_y     = '0;
        bus.i_last  = 1'b0;
        bus.i_ready = 1'b0;
        last_stall  = 1'b0;
        do_reset();

        // Eight samples of 1.0
        for (int i = 0; i < 8; i++) step(1'b1, 32'h0200_0000, 1'b0, 1'b1);
        drain();
        chk("t1 sum", last_res.sum, 64'h1000_0000);
        chk("t1 count", last_res.cnt, 8);

        // Back-to-back 16 samples
        for (int i = 0; i < 16; i++) step(1'b1, 32'h0200_0000, 1'b0, 1'b1);
        drain();
        chk("t2 sum", last_res.sum, 64'h1000_0000);

        // Held sum with stalled source, then handoff plus accept
        for (int i = 0; i < 8; i++) step(1'b1, 32'h0200_0000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h0040_0000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 32'h0040_0000, 1'b0, 1'b1);
        drain();
        chk("t3 sum", last_res.sum, 64'h0200_0000);

        // Early close with i_last
        step(1'b1, 32'h0100_0000, 1'b0, 1'b1);
        step(1'b1, 32'h0100_0000, 1'b0, 1'b1);
        step(1'b1, 32'h0100_0000, 1'b1, 1'b1);
        drain();
        chk("t4 sum", last_res.sum, 64'h0300_0000);
        chk("t4 count", last_res.cnt, 3);

        // Reset mid-block discards the partial block
        for (int i = 0; i < 4; i++) step(1'b1, 32'h0200_0000, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 32'h0200_0000, 1'b0, 1'b1);
        drain();
        chk("t5 sum", last_res.sum, 64'h1000_0000);

        // Largest samples
        for (int i = 0; i < 8; i++) step(1'b1, 32'hFFFF_FFFF, (i == 7), 1'b1);
        drain();
`ifdef EXP_ACC_SAT_EN
        chk("t6 sum", last_res.sum, 64'hFFFF_FFFF);
        chk("t6 ovf", last_res.ovf, 1'b1);
`else
        chk("t6 sum", last_res.sum, 64'h7_FFFF_FFF8);
        chk("t6 ovf", last_res.ovf, 1'b0);
`endif

        // Randomized run; a stalled sample is held until consumed
        hv = 0; hy = 0; hl = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            if (!last_stall) begin
                hv = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0:       hy = 32'h0200_0000;
                    1:       hy = 32'h0100_0000;
                    2:       hy = 32'hFFFF_FFFF;
                    default: hy = $urandom;
                endcase
                hl = ($urandom_range(0, 5) == 0);
            end
            step(hv, hy, hl, ($urandom_range(0, 2) != 0));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
